// File: rtl/board_io_pkg.sv
// Shared types and constants for the board push-button input path.
package board_io_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_PRESS_WAIT,
    KEY_HELD,
    KEY_RELEASE_WAIT
  } key_state_e;

  localparam int CLK_HZ      = 50000000;
  localparam int DEBOUNCE_MS = 20;

  // Width of a counter that must hold the values 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM and, with KEY_REPEAT_EN
// defined, an auto-repeat counter that re-pulses press while the key stays held.
module key_debounce_ch
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic            IDLE_RAW = (ACTIVE_LOW != 0);

  logic [1:0]    sync_q;
  logic          pressed;
  key_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          press_q;
  logic          release_q;

  // Synchroniser resets to the raw level of a released key so no false press follows reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {IDLE_RAW, IDLE_RAW};
    end else begin
      sync_q <= {sync_q[0], key_raw_i};
    end
  end

  assign pressed = sync_q[1] ^ IDLE_RAW;
  assign cnt_d   = cnt_q + 1'b1;

`ifdef KEY_REPEAT_EN
  localparam int              RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int              RW        = cnt_width(RPT_MAX);
  localparam logic [RW-1:0]   RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]   RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rptCnt_q;
  logic [RW-1:0] rptCnt_d;
  logic          rptArmed_q;
  logic [RW-1:0] rptLimit;

  assign rptCnt_d = rptCnt_q + 1'b1;
  assign rptLimit = rptArmed_q ? RPT_NEXT : RPT_FIRST;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= KEY_IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rptCnt_q   <= '0;
      rptArmed_q <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        KEY_IDLE: begin
          if (pressed) begin
            state_q <= KEY_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        KEY_PRESS_WAIT: begin
          if (!pressed) begin
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= KEY_HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        KEY_HELD: begin
          if (!pressed) begin
            state_q <= KEY_RELEASE_WAIT;
            cnt_q   <= '0;
          end
`ifdef KEY_REPEAT_EN
          else if (rptCnt_q == rptLimit) begin
            press_q    <= 1'b1;
            rptCnt_q   <= '0;
            rptArmed_q <= 1'b1;
          end else begin
            rptCnt_q <= rptCnt_d;
          end
`endif
        end
        KEY_RELEASE_WAIT: begin
          if (pressed) begin
            state_q <= KEY_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= KEY_IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= KEY_IDLE;
          cnt_q   <= '0;
        end
      endcase
`ifdef KEY_REPEAT_EN
      // Any cycle outside HELD, or the cycle that leaves it, restarts the repeat timing.
      if (state_q != KEY_HELD || !pressed) begin
        rptCnt_q   <= '0;
        rptArmed_q <= 1'b0;
      end
`endif
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounced push-button bank: NUM_KEYS independent channels giving clean levels and
// one-cycle press/release pulses. Define KEY_REPEAT_EN to enable auto-repeat on held keys.
module key_debounce
  import board_io_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .key_raw_i (KEY[g]),
      .level_o   (key_level[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g])
    );
  end

endmodule
